// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// serial_pkg : shared widths, last bit index and FSM state encoding
// Revision   : 1.0
// ============================================================================
package serial_pkg;

  localparam int WORD_W   = 32;
  localparam int CNT_W    = 5;
  localparam int LAST_IDX = WORD_W - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/word_serializer_32_if.sv
`default_nettype none
// ============================================================================
// word_serializer_32_if : word handshake in, serial bit stream out
// Revision              : 1.0
// ============================================================================
interface word_serializer_32_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 5
);

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_out;
  logic              ser_valid;
  logic [CNT_W-1:0]  bit_idx;
  logic              frame_start;
  logic              frame_done;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, bit_idx, frame_start, frame_done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, bit_idx, frame_start, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/bit_index_counter.sv
`default_nettype none
// ============================================================================
// bit_index_counter : frame bit index with clear-to-zero, saturating increment
//                     and terminal count at LAST
// Revision          : 1.0
// ============================================================================
module bit_index_counter #(
  parameter int CNT_W = 5,
  parameter int LAST  = 31
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr,
  input  wire logic             inc,
  output logic [CNT_W-1:0]      cnt,
  output logic                  tc
);

  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(LAST);

  // Holding at LAST keeps the index from running past the frame end.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == LAST_V);

endmodule
`default_nettype wire

// File: rtl/word_serializer_32.sv
`default_nettype none
// ============================================================================
// word_serializer_32 : valid/ready word in, one bit per clock out, gapless
//                      back-to-back frames. Define WORD_SERIALIZER_PARITY_EN
//                      to append an even-parity bit after each word.
// Revision           : 1.0
// ============================================================================
module word_serializer_32 #(
  parameter int WORD_W    = serial_pkg::WORD_W,
  parameter int CNT_W     = serial_pkg::CNT_W,
  parameter int MSB_FIRST = 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  word_serializer_32_if.slave bus
);

  import serial_pkg::*;

  state_t            state;
  state_t            state_nx;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] load_word;
  logic [CNT_W-1:0]  idx;
  logic              tc;
  logic              last_cycle;
  logic              ready;
  logic              accept;
  logic              cnt_clr;
  logic              cnt_inc;

`ifdef WORD_SERIALIZER_PARITY_EN
  logic parity_bit;
  assign last_cycle = (state == PARITY);
`else
  assign last_cycle = (state == SHIFT) && tc;
`endif

  assign ready  = !reset && ((state == IDLE) || last_cycle);
  assign accept = bus.in_valid && ready;

  // The output tap is always the top bit, so LSB-first words load reversed.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign load_word = bus.in_data;
    end else begin : g_lsb_first
      for (genvar i = 0; i < WORD_W; i++) begin : g_rev
        assign load_word[i] = bus.in_data[WORD_W-1-i];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) state_nx = SHIFT;
      end
      SHIFT: begin
        if (tc) begin
`ifdef WORD_SERIALIZER_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef WORD_SERIALIZER_PARITY_EN
      PARITY: begin
        state_nx = accept ? SHIFT : IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (accept) begin
      shift_reg <= load_word;
    end else if (state == SHIFT) begin
      shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
    end
  end

`ifdef WORD_SERIALIZER_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^bus.in_data;
    end
  end
`endif

  // Idle and the final frame cycle both return the index to zero.
  assign cnt_clr = (state == IDLE) || last_cycle;
  assign cnt_inc = (state == SHIFT);

  bit_index_counter #(
    .CNT_W (CNT_W),
    .LAST  (WORD_W - 1)
  ) u_bit_index_counter (
    .clk (clk),
    .rst (reset),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (idx),
    .tc  (tc)
  );

  always_comb begin
    bus.ser_out   = 1'b0;
    bus.ser_valid = 1'b0;
    case (state)
      SHIFT: begin
        bus.ser_out   = shift_reg[WORD_W-1];
        bus.ser_valid = 1'b1;
      end
`ifdef WORD_SERIALIZER_PARITY_EN
      PARITY: begin
        bus.ser_out   = parity_bit;
        bus.ser_valid = 1'b1;
      end
`endif
      default: begin
        bus.ser_out   = 1'b0;
        bus.ser_valid = 1'b0;
      end
    endcase
  end

  assign bus.in_ready    = ready;
  assign bus.bit_idx     = idx;
  assign bus.frame_start = (state == SHIFT) && (idx == '0);
  assign bus.frame_done  = last_cycle;

endmodule
`default_nettype wire
